// File: rtl/wm8731_pkg.sv
// Shared constants, state encoding and word-packing helper for the WM8731
// configuration sequencer.
package wm8731_pkg;

    localparam logic [7:0] DEF_DEV_ADDR = 8'h34;

    localparam logic [6:0] R_LLINE  = 7'h00;
    localparam logic [6:0] R_RLINE  = 7'h01;
    localparam logic [6:0] R_LHPOUT = 7'h02;
    localparam logic [6:0] R_RHPOUT = 7'h03;
    localparam logic [6:0] R_APATH  = 7'h04;
    localparam logic [6:0] R_DPATH  = 7'h05;
    localparam logic [6:0] R_PDOWN  = 7'h06;
    localparam logic [6:0] R_DAIF   = 7'h07;
    localparam logic [6:0] R_SRATE  = 7'h08;
    localparam logic [6:0] R_ACTIVE = 7'h09;
    localparam logic [6:0] R_RESET  = 7'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic logic [23:0] mk_word(input logic [7:0] dev,
                                            input logic [6:0] addr,
                                            input logic [8:0] data);
        return {dev, addr, data};
    endfunction

endpackage

// File: rtl/wm8731_cfg_seq_if.sv
// Handshake bundle between the sequencer (master) and the i2cc/control side (slave).
interface wm8731_cfg_seq_if;
    logic        start;
    logic        i2c_idle;
    logic [23:0] din;
    logic        wr_i2c;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  idx;

    modport master (
        input  start, i2c_idle,
        output din, wr_i2c, busy, done, err, idx
    );

    modport slave (
        output start, i2c_idle,
        input  din, wr_i2c, busy, done, err, idx
    );
endinterface

// File: rtl/wm8731_cfg_rom.sv
// Fixed WM8731 register-write table; indices past the last entry are invalid.
module wm8731_cfg_rom
    import wm8731_pkg::*;
(
    input  logic [3:0] i_idx,
    output logic [6:0] o_addr,
    output logic [8:0] o_data,
    output logic       o_valid
);

    always_comb begin
        o_addr  = '0;
        o_data  = '0;
        o_valid = 1'b1;
        case (i_idx)
            4'd0:    begin o_addr = R_RESET;  o_data = 9'h000; end
            4'd1:    begin o_addr = R_LLINE;  o_data = 9'h017; end
            4'd2:    begin o_addr = R_RLINE;  o_data = 9'h017; end
            4'd3:    begin o_addr = R_LHPOUT; o_data = 9'h079; end
            4'd4:    begin o_addr = R_RHPOUT; o_data = 9'h079; end
            4'd5:    begin o_addr = R_APATH;  o_data = 9'h012; end
            4'd6:    begin o_addr = R_DPATH;  o_data = 9'h000; end
            4'd7:    begin o_addr = R_PDOWN;  o_data = 9'h000; end
            4'd8:    begin o_addr = R_DAIF;   o_data = 9'h002; end
            4'd9:    begin o_addr = R_SRATE;  o_data = 9'h000; end
            4'd10:   begin o_addr = R_ACTIVE; o_data = 9'h001; end
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/wm8731_cfg_seq.sv
// WM8731 configuration sequencer: walks the register table, strobing each
// 24-bit word into i2cc and flagging writes that never saw i2cc go busy.
module wm8731_cfg_seq
    import wm8731_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR     = DEF_DEV_ADDR,
    parameter int unsigned NUM_REGS     = 11,
    parameter int unsigned INIT_DELAY   = 1000,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    wm8731_cfg_seq_if.master    cfg
);

    localparam int unsigned DW       = $clog2(INIT_DELAY) + 1;
    localparam int unsigned TW       = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_dcnt;
    logic [TW-1:0] r_tcnt;
    logic [3:0]    r_idx;
    logic [3:0]    w_rom_idx;
    logic [23:0]   r_din;
    logic          r_err;
    logic [6:0]    w_rom_addr;
    logic [8:0]    w_rom_data;
    logic          w_rom_valid;
    logic          w_wr;
    logic          w_busy;
    logic          w_done;

    // The word is fetched one index ahead when leaving NEXT so din is ready in ISSUE.
    assign w_rom_idx = (r_state == ST_NEXT) ? r_idx + 4'd1 : r_idx;

    wm8731_cfg_rom u_rom (
        .i_idx   (w_rom_idx),
        .o_addr  (w_rom_addr),
        .o_data  (w_rom_data),
        .o_valid (w_rom_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (cfg.start) w_state_nxt = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (r_dcnt == '0 && cfg.i2c_idle) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!cfg.i2c_idle)      w_state_nxt = ST_WAIT_IDLE;
                else if (r_tcnt == '0)  w_state_nxt = ST_NEXT;
            end
            ST_WAIT_IDLE: begin
                if (cfg.i2c_idle) w_state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                w_state_nxt = (r_idx == LAST_IDX) ? ST_DONE : ST_ISSUE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr   = (r_state == ST_ISSUE);
        w_done = (r_state == ST_DONE);
        w_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dcnt <= '0;
            r_tcnt <= '0;
            r_idx  <= '0;
            r_din  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (cfg.start) begin
                        r_dcnt <= DW'(INIT_DELAY);
                        r_idx  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                ST_WAIT_INIT: begin
                    if (r_dcnt != '0) r_dcnt <= r_dcnt - DW'(1);
                end
                ST_ISSUE: begin
                    r_tcnt <= TW'(BUSY_TIMEOUT);
                end
                ST_WAIT_BUSY: begin
                    if (cfg.i2c_idle) begin
                        if (r_tcnt == '0) r_err  <= 1'b1;
                        else              r_tcnt <= r_tcnt - TW'(1);
                    end
                end
                ST_NEXT: begin
                    if (r_idx != LAST_IDX) r_idx <= r_idx + 4'd1;
                end
                default: ;
            endcase
            if (w_state_nxt == ST_ISSUE) begin
                r_din <= w_rom_valid ? mk_word(DEV_ADDR, w_rom_addr, w_rom_data) : '0;
            end
        end
    end

    assign cfg.din    = r_din;
    assign cfg.wr_i2c = w_wr;
    assign cfg.busy   = w_busy;
    assign cfg.done   = w_done;
    assign cfg.err    = r_err;
    assign cfg.idx    = r_idx;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Directed bench for wm8731_cfg_seq with a behavioural i2cc model and a
// scoreboard of expected I2C words.
module tb_wm8731_cfg_seq;

    localparam int unsigned INIT_D = 10;

    typedef struct {
        logic [3:0]  idx;
        logic [23:0] din;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wm8731_cfg_seq_if ifc();

    wm8731_cfg_seq #(
        .INIT_DELAY (INIT_D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cfg   (ifc)
    );

    logic [23:0] exp_table [11] = '{
        24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
        24'h340A00, 24'h340C00, 24'h340E02, 24'h341000, 24'h341201
    };

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_count = 0;
    logic        prev_wr = 1'b0;
    logic [23:0] last_din = '0;
    bit          mon_en = 1'b0;
    int          skip_entry = -1;
    bit          hold_low = 1'b0;

    // i2cc model: idle drops two cycles after a strobe, returns ~50 cycles later
    logic       m_idle;
    int         m_state;
    int         m_cnt;
    always @(posedge clk) begin
        if (reset) begin
            m_idle  <= 1'b1;
            m_state <= 0;
            m_cnt   <= 0;
        end else begin
            case (m_state)
                0: if (ifc.wr_i2c === 1'b1 && int'(ifc.idx) != skip_entry) m_state <= 1;
                1: begin m_idle <= 1'b0; m_cnt <= 50; m_state <= 2; end
                default: begin
                    if (m_cnt == 1) begin m_idle <= 1'b1; m_state <= 0; end
                    else m_cnt <= m_cnt - 1;
                end
            endcase
        end
    end
    assign ifc.i2c_idle = m_idle & ~hold_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run();
        for (int i = 0; i < 11; i++) sb.push_back('{4'(i), exp_table[i]});
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (ifc.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", {31'b0, ifc.done}, 1);
    endtask

    task automatic wait_wr(input int want, input int budget);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            if (ifc.wr_i2c === 1'b1 && int'(ifc.idx) == want) hit = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("wr_reached", {31'b0, hit}, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_din"},  ifc.din, 0);
        chk({tag, "_wr"},   {31'b0, ifc.wr_i2c}, 0);
        chk({tag, "_busy"}, {31'b0, ifc.busy}, 0);
        chk({tag, "_done"}, {31'b0, ifc.done}, 0);
        chk({tag, "_err"},  {31'b0, ifc.err}, 0);
        chk({tag, "_idx"},  {28'b0, ifc.idx}, 0);
    endtask

    // Scoreboard monitor: pops one expected word per strobe, checks din holds otherwise
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (ifc.wr_i2c === 1'b1) begin
                chk("wr_width", {31'b0, prev_wr}, 0);
                wr_count++;
                chk("sb_has_entry", {31'b0, (sb.size() != 0)}, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("din", ifc.din, e.din);
                    chk("idx", {28'b0, ifc.idx}, {28'b0, e.idx});
                    last_din = e.din;
                end
            end else begin
                chk("din_stable", ifc.din, last_din);
            end
        end
        prev_wr = ifc.wr_i2c;
    end

    initial begin
        ifc.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;
        last_din = '0;
        mon_en = 1'b1;

        // Run 1: nominal sequence and first-strobe latency
        push_run();
        pulse_start();
        repeat (10) @(negedge clk);
        chk("pre_first_wr", {31'b0, ifc.wr_i2c}, 0);
        chk("busy_in_init", {31'b0, ifc.busy}, 1);
        @(negedge clk);
        chk("first_wr", {31'b0, ifc.wr_i2c}, 1);
        chk("first_din", ifc.din, 32'h341E00);
        wait_done(2000);
        chk("r1_err", {31'b0, ifc.err}, 0);
        chk("r1_busy", {31'b0, ifc.busy}, 0);
        chk("r1_wr_count", wr_count, 11);
        chk("r1_sb_empty", sb.size(), 0);
        chk("r1_last_idx", {28'b0, ifc.idx}, 10);
        chk("r1_last_din", ifc.din, 32'h341201);

        // Run 2: entry 3 never answered, start pulses ignored mid-run
        skip_entry = 3;
        wr_count = 0;
        push_run();
        pulse_start();
        chk("r2_busy", {31'b0, ifc.busy}, 1);
        chk("r2_done_clr", {31'b0, ifc.done}, 0);
        chk("r2_idx_clr", {28'b0, ifc.idx}, 0);
        wait_wr(3, 1000);
        chk("r2_err_before", {31'b0, ifc.err}, 0);
        repeat (17) @(negedge clk);
        chk("r2_err_edge", {31'b0, ifc.err}, 0);
        @(negedge clk);
        chk("r2_err_set", {31'b0, ifc.err}, 1);
        wait_wr(5, 1000);
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_done(2000);
        chk("r2_err_sticky", {31'b0, ifc.err}, 1);
        chk("r2_wr_count", wr_count, 11);
        chk("r2_sb_empty", sb.size(), 0);

        // Run 3: start from DONE clears err; reset during WAIT_IDLE of entry 6
        skip_entry = -1;
        wr_count = 0;
        push_run();
        pulse_start();
        chk("r3_err_clr", {31'b0, ifc.err}, 0);
        chk("r3_done_clr", {31'b0, ifc.done}, 0);
        chk("r3_busy", {31'b0, ifc.busy}, 1);
        wait_wr(6, 2000);
        repeat (5) @(negedge clk);
        chk("r3_busy_mid", {31'b0, ifc.busy}, 1);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b0;
        sb.delete();
        last_din = '0;
        wr_count = 0;
        mon_en = 1'b1;
        repeat (100) @(negedge clk);
        chk("no_wr_after_rst", wr_count, 0);
        chk("idle_after_rst", {31'b0, ifc.busy}, 0);
        push_run();
        pulse_start();
        wait_done(2000);
        chk("r3_wr_count", wr_count, 11);
        chk("r3_sb_empty", sb.size(), 0);
        chk("r3_err", {31'b0, ifc.err}, 0);

        // Run 4: i2c_idle held low past the init delay
        hold_low = 1'b1;
        wr_count = 0;
        push_run();
        pulse_start();
        repeat (30) @(negedge clk);
        chk("hold_no_wr", wr_count, 0);
        chk("hold_busy", {31'b0, ifc.busy}, 1);
        chk("hold_wr_low", {31'b0, ifc.wr_i2c}, 0);
        hold_low = 1'b0;
        @(negedge clk);
        chk("release_wr", {31'b0, ifc.wr_i2c}, 1);
        chk("release_din", ifc.din, 32'h341E00);
        wait_done(2000);
        chk("r4_wr_count", wr_count, 11);
        chk("r4_err", {31'b0, ifc.err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
